// File: rtl/ef_smsdac_pkg.sv
// Shared constants for the segmented mismatch-shaping DAC: 3-level cell codes
// and the 16-bit dither LFSR definition.
package ef_smsdac_pkg;

  localparam logic [1:0] CODE_P = 2'b10;
  localparam logic [1:0] CODE_Z = 2'b00;
  localparam logic [1:0] CODE_N = 2'b01;

  localparam int          LFSR_W        = 16;
  // Taps x^16 + x^14 + x^13 + x^11 + 1 land on bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ef_smsdac_lfsr16.sv
// 16-bit Fibonacci dither LFSR; advances once per accepted sample and exposes
// its low NR bits as per-segment random choices.
module ef_smsdac_lfsr16
  import ef_smsdac_pkg::*;
#(
  parameter int          NR   = 3,
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  output logic [NR-1:0] r_bits
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    if (adv) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign r_bits = lfsr_q[NR-1:0];

endmodule

// File: rtl/ef_smsdac_sb.sv
// One first-order switching block: peels a 3-level unit term off c_in and
// hands the exact half of the remainder to the next stage.
module ef_smsdac_sb
  import ef_smsdac_pkg::*;
#(
  parameter int CW = 9
) (
  input  logic [CW-1:0] c_in,
  input  logic          st_in,
  input  logic          r_in,
  input  logic          en_dith,
  output logic [1:0]    code,
  output logic [CW-2:0] c_out,
  output logic          st_out
);

  logic sgn_s;

  // Odd inputs take +1 or -1 so the remainder is even; the sign flips state.
  always_comb begin
    code   = CODE_Z;
    c_out  = c_in[CW-1:1];
    st_out = st_in;
    sgn_s  = 1'b0;
    if (c_in[0]) begin
      sgn_s  = st_in ^ (en_dith & r_in);
      st_out = ~sgn_s;
      if (sgn_s) begin
        code  = CODE_N;
        c_out = c_in[CW-1:1] + {{(CW-2){1'b0}}, 1'b1};
      end else begin
        code  = CODE_P;
        c_out = c_in[CW-1:1];
      end
    end else begin
      code   = CODE_Z;
      c_out  = c_in[CW-1:1];
      st_out = st_in;
    end
  end

endmodule

// File: rtl/ef_smsdac_seg_p.sv
// Segmented mismatch-shaping DAC core: sample register, NSEG-deep chain of
// switching blocks, and registered 3-level segment / MSB-residue outputs.
module ef_smsdac_seg_p
  import ef_smsdac_pkg::*;
#(
  parameter int          W         = 8,
  parameter int          NSEG      = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                smp_en,
  input  logic [W-1:0]        d_in,
  input  logic                en_dith,
  input  logic                mute,
  output logic [2*NSEG-1:0]   d_out_seg,
  output logic [W-NSEG:0]     d_out_msb,
  output logic                out_valid
);

  localparam int          CW  = W + 1;
  localparam int          MW  = W - NSEG + 1;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0]      x_q,     x_d;
  logic              dith_q,  dith_d;
  logic              stb_q,   stb_d;
  logic [NSEG-1:0]   st_q,    st_d;
  logic [2*NSEG-1:0] seg_q,   seg_d;
  logic [MW-1:0]     msb_q,   msb_d;
  logic              valid_q, valid_d;

  logic [NSEG-1:0]   r_s;
  logic [NSEG-1:0]   st_nxt_s;
  logic [2*NSEG-1:0] code_s;
  logic [MW-1:0]     msb_s;

  ef_smsdac_lfsr16 #(
    .NR   (NSEG),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .adv    (stb_q),
    .r_bits (r_s)
  );

  // Stage j consumes a (CW-j)-bit value and yields a (CW-j-1)-bit remainder.
  for (genvar j = 0; j < NSEG; j++) begin : g_sb
    logic [CW-j-1:0] c_in_s;
    logic [CW-j-2:0] c_out_s;

    if (j == 0) begin : g_first
      assign c_in_s = {1'b0, x_q};
    end else begin : g_next
      assign c_in_s = g_sb[j-1].c_out_s;
    end

    ef_smsdac_sb #(
      .CW (CW - j)
    ) u_sb (
      .c_in    (c_in_s),
      .st_in   (st_q[j]),
      .r_in    (r_s[j]),
      .en_dith (dith_q),
      .code    (code_s[2*j+1:2*j]),
      .c_out   (c_out_s),
      .st_out  (st_nxt_s[j])
    );
  end

  assign msb_s = g_sb[NSEG-1].c_out_s;

  // Stage A captures the (possibly muted) sample; stage B registers the encode.
  always_comb begin
    x_d     = x_q;
    dith_d  = dith_q;
    stb_d   = 1'b0;
    seg_d   = seg_q;
    msb_d   = msb_q;
    st_d    = st_q;
    valid_d = 1'b0;
    if (smp_en) begin
      x_d    = mute ? MID : d_in;
      dith_d = en_dith;
      stb_d  = 1'b1;
    end else begin
      stb_d  = 1'b0;
    end
    if (stb_q) begin
      seg_d   = code_s;
      msb_d   = msb_s;
      st_d    = st_nxt_s;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      dith_q  <= 1'b0;
      stb_q   <= 1'b0;
      st_q    <= '0;
      seg_q   <= '0;
      msb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      dith_q  <= dith_d;
      stb_q   <= stb_d;
      st_q    <= st_d;
      seg_q   <= seg_d;
      msb_q   <= msb_d;
      valid_q <= valid_d;
    end
  end

  assign d_out_seg = seg_q;
  assign d_out_msb = msb_q;
  assign out_valid = valid_q;

endmodule
